// File: rtl/seq_detect_pkg.sv
// Shared types and reset defaults for the
// configurable serial sequence detector.
package seq_detect_pkg;

    typedef enum logic [0:0] {
        SEARCH = 1'b0,
        HIT    = 1'b1
    } state_e;

    localparam int MAX_LEN_DEF = 8;
    localparam int CNT_W_DEF   = 8;

    localparam logic [7:0] RST_PATTERN_DEF = 8'b0011_1001;
    localparam int         RST_LEN_DEF     = 6;

endpackage

// File: rtl/seq_detect_cfg_if.sv
// Data, configuration and status bundle
// of the sequence detector.
interface seq_detect_cfg_if
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF
);

    localparam int LW = $clog2(MAX_LEN + 1);

    logic               in;
    logic               in_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LW-1:0]      cfg_len;
    logic               cfg_overlap;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic               cfg_err;

    modport master (
        output in, in_valid,
        output cfg_load, cfg_pattern,
        output cfg_len, cfg_overlap,
        input  match, match_count,
        input  cfg_err
    );

    modport slave (
        input  in, in_valid,
        input  cfg_load, cfg_pattern,
        input  cfg_len, cfg_overlap,
        output match, match_count,
        output cfg_err
    );

endinterface

// File: rtl/seq_detect_cfg_sat_counter.sv
// Up-counter that sticks at all-ones
// instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Clear wins over increment; hold at max.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign count = cnt_q;

endmodule

// File: rtl/seq_detect_cfg.sv
// Runtime-configurable serial pattern detector
// with overlap control and saturating hit count.
module seq_detect_cfg
    import seq_detect_pkg::*;
#(
    parameter int MAX_LEN = MAX_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF,
    parameter logic [MAX_LEN-1:0] RST_PATTERN =
        MAX_LEN'(RST_PATTERN_DEF),
    parameter int RST_LEN = RST_LEN_DEF
) (
    input logic              clk,
    input logic              rst,
    seq_detect_cfg_if.slave  bus
);

    localparam int LW = $clog2(MAX_LEN + 1);
    localparam logic [LW-1:0] FILL_MAX =
        LW'(MAX_LEN);

    state_e             state_q, state_d;
    logic [MAX_LEN-1:0] pat_q, pat_d;
    logic [LW-1:0]      len_q, len_d;
    logic               ovl_q, ovl_d;
    logic [MAX_LEN-1:0] hist_q, hist_d;
    logic [LW-1:0]      fill_q, fill_d;
    logic               err_q, err_d;

    logic [MAX_LEN-1:0] mask;
    logic [MAX_LEN-1:0] hist_sh;
    logic [LW-1:0]      fill_sh;
    logic               cfg_ok;
    logic               hit;
    logic               cnt_clr;

    assign cfg_ok = (bus.cfg_len != '0) &&
                    (bus.cfg_len <= FILL_MAX);

    // Low len bits set; upper pattern bits ignored.
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            mask[i] = (LW'(i) < len_q);
        end
    end

    // Next-state: config load first, else shift.
    always_comb begin
        pat_d   = pat_q;
        len_d   = len_q;
        ovl_d   = ovl_q;
        hist_d  = hist_q;
        fill_d  = fill_q;
        state_d = state_q;
        err_d   = err_q;
        hit     = 1'b0;
        cnt_clr = 1'b0;
        hist_sh = (hist_q << 1) | MAX_LEN'(bus.in);
        fill_sh = (fill_q == FILL_MAX) ?
                  fill_q : fill_q + LW'(1);
        if (bus.cfg_load) begin
            if (cfg_ok) begin
                pat_d   = bus.cfg_pattern;
                len_d   = bus.cfg_len;
                ovl_d   = bus.cfg_overlap;
                hist_d  = '0;
                fill_d  = '0;
                state_d = SEARCH;
                cnt_clr = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end else begin
            hit = bus.in_valid &&
                  (fill_sh >= len_q) &&
                  (((hist_sh ^ pat_q) & mask) == '0);
            if (bus.in_valid) begin
                hist_d = hist_sh;
                fill_d = (hit && !ovl_q) ?
                         '0 : fill_sh;
            end
            state_d = hit ? HIT : SEARCH;
        end
    end

    // State and configuration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SEARCH;
            pat_q   <= RST_PATTERN;
            len_q   <= LW'(RST_LEN);
            ovl_q   <= 1'b1;
            hist_q  <= '0;
            fill_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            ovl_q   <= ovl_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
            err_q   <= err_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .inc   (hit),
        .count (bus.match_count)
    );

    assign bus.match   = (state_q == HIT);
    assign bus.cfg_err = err_q;

endmodule

// File: tb/tb_seq_detect_cfg.sv
// Randomized and directed checks of seq_detect_cfg
// against a queue-based reference model.
module tb_seq_detect_cfg;

    localparam int ML = 8;
    localparam int CW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    seq_detect_cfg_if #(.MAX_LEN(ML), .CNT_W(CW)) bus ();
    seq_detect_cfg_if #(.MAX_LEN(ML), .CNT_W(2))  bus2 ();

    seq_detect_cfg #(.MAX_LEN(ML), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    seq_detect_cfg #(.MAX_LEN(ML), .CNT_W(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int errors = 0;
    int checks = 0;

    logic [ML-1:0] m_pat   = 8'b0011_1001;
    int            m_len   = 6;
    bit            m_ovl   = 1'b1;
    bit            q[$];
    bit            m_match = 1'b0;
    logic [CW-1:0] m_cnt   = '0;
    bit            m_err   = 1'b0;

    // Reference: matched when the last len consumed bits,
    // oldest first, read pattern[len-1] down to pattern[0].
    function automatic void model_step();
        bit h;
        if (rst) begin
            m_pat = 8'b0011_1001; m_len = 6; m_ovl = 1'b1;
            q.delete(); m_match = 1'b0; m_cnt = '0; m_err = 1'b0;
        end else if (bus.cfg_load) begin
            if (bus.cfg_len != 0 && int'(bus.cfg_len) <= ML) begin
                m_pat = bus.cfg_pattern; m_len = int'(bus.cfg_len);
                m_ovl = bus.cfg_overlap; q.delete();
                m_match = 1'b0; m_cnt = '0;
            end else begin
                m_err = 1'b1;
            end
        end else begin
            h = 1'b0;
            if (bus.in_valid) begin
                q.push_back(bus.in);
                if (q.size() > ML) void'(q.pop_front());
                if (q.size() >= m_len) begin
                    h = 1'b1;
                    for (int k = 0; k < m_len; k++)
                        if (q[q.size() - m_len + k] != m_pat[m_len - 1 - k])
                            h = 1'b0;
                end
            end
            if (h) begin
                if (m_cnt != '1) m_cnt = m_cnt + 1'b1;
                if (!m_ovl) q.delete();
            end
            m_match = h;
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle();
        bus.in = 0; bus.in_valid = 0; bus.cfg_load = 0;
        bus.cfg_pattern = '0; bus.cfg_len = '0; bus.cfg_overlap = 0;
        bus2.in = 0; bus2.in_valid = 0; bus2.cfg_load = 0;
        bus2.cfg_pattern = '0; bus2.cfg_len = '0; bus2.cfg_overlap = 0;
    endtask

    task automatic feed(input bit b);
        bus.in = b; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic load(input logic [ML-1:0] p, input int l, input bit o);
        bus.cfg_pattern = p; bus.cfg_len = 4'(l);
        bus.cfg_overlap = o; bus.cfg_load = 1'b1;
        tick();
        bus.cfg_load = 1'b0;
    endtask

    task automatic do_rst();
        rst = 1'b1; tick(); rst = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1; tick(); tick(); rst = 1'b0;
        checks++;
        if (bus.match !== 1'b0 || bus.match_count !== 8'd0 || bus.cfg_err !== 1'b0) begin
            errors++;
            $display("FAIL reset got m=%b c=%0d e=%b exp 0/0/0",
                     bus.match, bus.match_count, bus.cfg_err);
        end
    endtask

    task automatic test_basic();
        bit s[6] = '{1, 1, 1, 0, 0, 1};
        bit e[6] = '{0, 0, 0, 0, 0, 1};
        do_rst();
        for (int i = 0; i < 6; i++) begin
            feed(s[i]);
            checks++;
            if (bus.match !== e[i] || e[i] != m_match) begin
                errors++;
                $display("FAIL basic bit%0d got=%b exp=%b model=%b",
                         i, bus.match, e[i], m_match);
            end
        end
        checks++;
        if (bus.match_count !== 8'd1) begin
            errors++;
            $display("FAIL basic_count got=%0d exp=1", bus.match_count);
        end
        tick();
        checks++;
        if (bus.match !== 1'b0) begin
            errors++;
            $display("FAIL basic_drop got=%b exp=0", bus.match);
        end
    endtask

    task automatic test_overlap();
        bit s[5]  = '{1, 0, 1, 0, 1};
        bit e1[5] = '{0, 0, 1, 0, 1};
        bit e0[5] = '{0, 0, 1, 0, 0};
        for (int o = 1; o >= 0; o--) begin
            load(8'b101, 3, o[0]);
            for (int i = 0; i < 5; i++) begin
                feed(s[i]);
                checks++;
                if (bus.match !== (o == 1 ? e1[i] : e0[i])) begin
                    errors++;
                    $display("FAIL overlap%0d bit%0d got=%b exp=%b",
                             o, i, bus.match, o == 1 ? e1[i] : e0[i]);
                end
            end
            checks++;
            if (bus.match_count !== 8'(o + 1) || m_cnt != 8'(o + 1)) begin
                errors++;
                $display("FAIL overlap%0d_count got=%0d exp=%0d",
                         o, bus.match_count, o + 1);
            end
        end
    endtask

    task automatic test_gaps();
        bit s[7] = '{1, 1, 1, 1, 0, 0, 1};
        for (int g = 0; g < 2; g++) begin
            do_rst();
            for (int i = 0; i < 7; i++) begin
                feed(s[i]);
                checks++;
                if (bus.match !== (i == 6) || m_match != (i == 6)) begin
                    errors++;
                    $display("FAIL gaps%0d bit%0d got=%b exp=%b",
                             g, i, bus.match, i == 6);
                end
                if (g == 1 && (i == 2 || i == 4)) begin
                    tick(); tick();
                    checks++;
                    if (bus.match !== 1'b0) begin
                        errors++;
                        $display("FAIL gaps_idle bit%0d got=%b exp=0", i, bus.match);
                    end
                end
            end
            checks++;
            if (bus.match_count !== 8'd1) begin
                errors++;
                $display("FAIL gaps%0d_count got=%0d exp=1", g, bus.match_count);
            end
        end
    endtask

    task automatic test_illegal();
        bit s[6] = '{1, 1, 1, 0, 0, 1};
        do_rst();
        load(8'hFF, 0, 1'b0);
        checks++;
        if (bus.cfg_err !== 1'b1 || bus.match_count !== 8'd0) begin
            errors++;
            $display("FAIL illegal_len0 got e=%b c=%0d exp e=1 c=0",
                     bus.cfg_err, bus.match_count);
        end
        load(8'hAA, 9, 1'b0);
        for (int i = 0; i < 6; i++) feed(s[i]);
        checks++;
        if (bus.match !== 1'b1 || bus.match_count !== 8'd1 || bus.cfg_err !== 1'b1) begin
            errors++;
            $display("FAIL illegal_keep got m=%b c=%0d e=%b exp 1/1/1",
                     bus.match, bus.match_count, bus.cfg_err);
        end
    endtask

    task automatic test_priority();
        bit s[5] = '{1, 1, 0, 0, 1};
        do_rst();
        for (int i = 0; i < 5; i++) feed(i < 3 ? 1'b1 : 1'b0);
        bus.in = 1'b1; bus.in_valid = 1'b1;
        load(8'b0011_1001, 6, 1'b1);
        bus.in_valid = 1'b0;
        feed(1'b1);
        checks++;
        if (bus.match !== 1'b0 || bus.match_count !== 8'd0) begin
            errors++;
            $display("FAIL priority_discard got m=%b c=%0d exp 0/0",
                     bus.match, bus.match_count);
        end
        for (int i = 0; i < 5; i++) feed(s[i]);
        checks++;
        if (bus.match !== 1'b1 || bus.match_count !== 8'd1) begin
            errors++;
            $display("FAIL priority_match got m=%b c=%0d exp 1/1",
                     bus.match, bus.match_count);
        end
    endtask

    task automatic test_rst_mid();
        bit s[6] = '{1, 1, 1, 0, 0, 1};
        do_rst();
        for (int i = 0; i < 4; i++) feed(s[i]);
        bus.in = 1'b0; bus.in_valid = 1'b1;
        do_rst();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.match !== 1'b0 || bus.match_count !== 8'd0) begin
            errors++;
            $display("FAIL rst_mid got m=%b c=%0d exp 0/0",
                     bus.match, bus.match_count);
        end
        for (int i = 4; i < 6; i++) begin
            feed(s[i]);
            checks++;
            if (bus.match !== 1'b0) begin
                errors++;
                $display("FAIL rst_tail bit%0d got=%b exp=0", i, bus.match);
            end
        end
        for (int i = 0; i < 6; i++) feed(s[i]);
        bus.cfg_load = 1'b1; bus.cfg_len = 4'd2;
        do_rst();
        bus.cfg_load = 1'b0;
        checks++;
        if (bus.match !== 1'b0 || bus.match_count !== 8'd0) begin
            errors++;
            $display("FAIL rst_hit got m=%b c=%0d exp 0/0",
                     bus.match, bus.match_count);
        end
    endtask

    task automatic test_sat();
        bus2.cfg_pattern = 8'h01; bus2.cfg_len = 4'd1;
        bus2.cfg_overlap = 1'b1; bus2.cfg_load = 1'b1;
        tick();
        bus2.cfg_load = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            bus2.in = 1'b1; bus2.in_valid = 1'b1;
            tick();
            checks++;
            if (bus2.match !== 1'b1 || bus2.match_count !== 2'(i > 3 ? 3 : i)) begin
                errors++;
                $display("FAIL sat bit%0d got m=%b c=%0d exp m=1 c=%0d",
                         i, bus2.match, bus2.match_count, i > 3 ? 3 : i);
            end
        end
        bus2.in_valid = 1'b0;
        tick();
        checks++;
        if (bus2.match !== 1'b0 || bus2.match_count !== 2'd3) begin
            errors++;
            $display("FAIL sat_end got m=%b c=%0d exp 0/3",
                     bus2.match, bus2.match_count);
        end
    endtask

    task automatic test_random();
        int r;
        do_rst();
        for (int c = 0; c < 2000; c++) begin
            rst = ($urandom_range(0, 149) == 0);
            bus.cfg_load = ($urandom_range(0, 39) == 0);
            r = $urandom_range(0, 9);
            if (r < 8)       bus.cfg_len = 4'($urandom_range(1, 4));
            else if (r == 8) bus.cfg_len = $urandom_range(0, 1) ? 4'd0 : 4'd8;
            else             bus.cfg_len = 4'($urandom_range(9, 15));
            bus.cfg_pattern = 8'($urandom);
            bus.cfg_overlap = 1'($urandom);
            bus.in = 1'($urandom);
            bus.in_valid = ($urandom_range(0, 3) != 0);
            tick();
            checks++;
            if (bus.match !== m_match || bus.match_count !== m_cnt ||
                bus.cfg_err !== m_err) begin
                errors++;
                $display("FAIL random cyc%0d got m=%b c=%0d e=%b exp m=%b c=%0d e=%b",
                         c, bus.match, bus.match_count, bus.cfg_err,
                         m_match, m_cnt, m_err);
            end
        end
        rst = 1'b0;
        idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overlap();
        test_gaps();
        test_illegal();
        test_priority();
        test_rst_mid();
        test_sat();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
